// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, and hands the IF/ID register its pcInput/instructionInput
// pair. When nothing valid is available it outputs the all-zero bubble.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request outstanding at r_pc; deliver, buffer or discard on ready
// S_HOLD  | response captured under hazard; no request until hazard clears
// S_DRAIN | redirected while a request was pending; discard that response
// (3)     | unused encoding, recovers to S_FETCH
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        branchControlExInput,
  input  logic [31:0] branchTargetExInput,
  input  logic        jumpIdInput,
  input  logic [31:0] jumpTargetIdInput,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pcOutput,
  output logic [31:0] instructionOutput,
  output logic        instructionValidOutput
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_DRAIN  = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  // Low from reset until the first clock edge after release; keeps the
  // request line quiet in that window and freezes all state updates.
  logic        r_active;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_req_addr_nxt;
  logic [31:0] w_hold_instr_nxt;
  logic [31:0] w_hold_pc_nxt;

  logic        w_req;
  logic        w_ready;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;

  // The branch is the older instruction, so it wins over a same-cycle jump.
  assign w_redirect = branchControlExInput | jumpIdInput;
  assign w_target   = branchControlExInput ? branchTargetExInput : jumpTargetIdInput;
  assign w_pc_plus4 = r_pc + 32'd4;

  // A request is outstanding in FETCH and DRAIN only; ready is meaningless otherwise.
  assign w_req   = r_active & ((r_state == S_FETCH) | (r_state == S_DRAIN));
  assign w_ready = w_req & imemReady;

  // State, PC and buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= 32'd0;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_active     <= 1'b1;
    end
  end

  // Next-state decode and the combinational fetch/delivery outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_addr           = 32'd0;
    w_valid          = 1'b0;
    w_out_pc         = 32'd0;
    w_out_instr      = 32'd0;

    if (r_active) begin
      case (r_state)
        S_FETCH: begin
          w_addr = r_pc;
          if (w_ready) begin
            if (w_redirect) begin
              w_pc_nxt = w_target;
            end else if (hazard) begin
              w_hold_instr_nxt = imemData;
              w_hold_pc_nxt    = w_pc_plus4;
              w_state_nxt      = S_HOLD;
            end else begin
              w_valid     = 1'b1;
              w_out_instr = imemData;
              w_out_pc    = w_pc_plus4;
              w_pc_nxt    = w_pc_plus4;
            end
          end else if (w_redirect) begin
            w_req_addr_nxt = r_pc;
            w_pc_nxt       = w_target;
            w_state_nxt    = S_DRAIN;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_FETCH;
          end else begin
            w_valid     = 1'b1;
            w_out_instr = r_hold_instr;
            w_out_pc    = r_hold_pc;
            if (!hazard) begin
              w_pc_nxt    = r_hold_pc;
              w_state_nxt = S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          w_addr = r_req_addr;
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end
          if (w_ready) begin
            w_state_nxt = S_FETCH;
          end
        end
        default: begin
          w_state_nxt = S_FETCH;
        end
      endcase
    end
  end

  assign imemReq                = w_req;
  assign imemAddr               = w_addr;
  assign instructionValidOutput = w_valid;
  assign pcOutput               = w_out_pc;
  assign instructionOutput      = w_out_instr;

endmodule
